// File: rtl/sti_deserializer.sv
// STI serial receiver: collects 8/16/24/32-bit serial frames and recovers
// the original 16-bit word, undoing bit order, byte select and zero fill.
// Flags non-zero pad bits and frames that end early, and counts good frames.
module sti_deserializer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             si_data,
    input  logic             si_valid,
    input  logic [1:0]       pi_length,
    input  logic             pi_msb,
    input  logic             pi_low,
    input  logic             pi_fill,
    output logic [15:0]      po_data,
    output logic             po_valid,
    output logic             pad_err,
    output logic             frame_err,
    output logic [CNT_W-1:0] word_cnt
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [31:0]      r_sr;
    logic [5:0]       r_cnt;
    logic [1:0]       r_len;
    logic             r_msb;
    logic             r_low;
    logic             r_fill;
    logic [15:0]      r_po_data;
    logic             r_po_valid;
    logic             r_pad_err;
    logic             r_frame_err;
    logic [CNT_W-1:0] r_word_cnt;

    logic             w_first;
    logic [1:0]       w_len;
    logic             w_msb;
    logic             w_low;
    logic             w_fill;
    logic [31:0]      w_sr_base;
    logic [31:0]      w_sr_nxt;
    logic [5:0]       w_cnt_nxt;
    logic [5:0]       w_n;
    logic             w_done;
    logic [31:0]      w_field;
    logic [15:0]      w_word;
    logic             w_pad;

    // Current-bit view: in IDLE the incoming bit opens a frame, so the live
    // config inputs apply and the shift register/counter start from zero.
    always_comb begin
        w_first   = (r_state == S_IDLE);
        w_len     = w_first ? pi_length : r_len;
        w_msb     = w_first ? pi_msb    : r_msb;
        w_low     = w_first ? pi_low    : r_low;
        w_fill    = w_first ? pi_fill   : r_fill;
        w_sr_base = w_first ? 32'h0     : r_sr;
        w_sr_nxt  = w_msb ? {w_sr_base[30:0], si_data} : {si_data, w_sr_base[31:1]};
        w_cnt_nxt = (w_first ? 6'd0 : r_cnt) + 6'd1;
        w_n       = {1'b0, w_len, 3'b000} + 6'd8;
        w_done    = si_valid && (w_cnt_nxt == w_n);
    end

    // Right-align the N-bit field, then strip byte select / zero fill.
    always_comb begin
        w_field = 32'h0;
        w_word  = 16'h0;
        w_pad   = 1'b0;
        case (w_len)
            2'd0: w_field = {24'h0, (w_msb ? w_sr_nxt[7:0]  : w_sr_nxt[31:24])};
            2'd1: w_field = {16'h0, (w_msb ? w_sr_nxt[15:0] : w_sr_nxt[31:16])};
            2'd2: w_field = {8'h0,  (w_msb ? w_sr_nxt[23:0] : w_sr_nxt[31:8])};
            default: w_field = w_sr_nxt;
        endcase
        case (w_len)
            2'd0: w_word = w_low ? {w_field[7:0], 8'h00} : {8'h00, w_field[7:0]};
            2'd1: w_word = w_field[15:0];
            2'd2: begin
                w_word = w_fill ? w_field[23:8] : w_field[15:0];
                w_pad  = w_fill ? (|w_field[7:0]) : (|w_field[23:16]);
            end
            default: begin
                w_word = w_fill ? w_field[31:16] : w_field[15:0];
                w_pad  = w_fill ? (|w_field[15:0]) : (|w_field[31:16]);
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: stay in SHIFT while bits keep coming and the frame is open.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (si_valid && !w_done) w_state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                if (!si_valid || w_done) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Shift register, bit counter and first-bit config latch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sr   <= 32'h0;
            r_cnt  <= 6'd0;
            r_len  <= 2'd0;
            r_msb  <= 1'b0;
            r_low  <= 1'b0;
            r_fill <= 1'b0;
        end else if (si_valid) begin
            r_sr  <= w_sr_nxt;
            r_cnt <= w_done ? 6'd0 : w_cnt_nxt;
            if (w_first) begin
                r_len  <= pi_length;
                r_msb  <= pi_msb;
                r_low  <= pi_low;
                r_fill <= pi_fill;
            end
        end else begin
            // A gap discards any partial frame.
            r_sr  <= 32'h0;
            r_cnt <= 6'd0;
        end
    end

    // Registered outputs: word/valid/pad one cycle after the last bit,
    // frame_err one cycle after si_valid drops inside a frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_po_data   <= 16'h0;
            r_po_valid  <= 1'b0;
            r_pad_err   <= 1'b0;
            r_frame_err <= 1'b0;
            r_word_cnt  <= '0;
        end else begin
            r_po_valid  <= w_done;
            r_pad_err   <= w_done && w_pad;
            r_frame_err <= (r_state == S_SHIFT) && !si_valid;
            if (w_done) begin
                r_po_data  <= w_word;
                r_word_cnt <= r_word_cnt + 1'b1;
            end
        end
    end

    assign po_data   = r_po_data;
    assign po_valid  = r_po_valid;
    assign pad_err   = r_pad_err;
    assign frame_err = r_frame_err;
    assign word_cnt  = r_word_cnt;

endmodule

// File: tb/tb_sti_deserializer.sv
// Testbench for sti_deserializer: scoreboard of expected words pushed as
// frames are driven, popped and compared whenever po_valid pulses.
module tb_sti_deserializer;

    logic        clk;
    logic        reset;
    logic        si_data;
    logic        si_valid;
    logic [1:0]  pi_length;
    logic        pi_msb;
    logic        pi_low;
    logic        pi_fill;
    logic [15:0] po_data;
    logic        po_valid;
    logic        pad_err;
    logic        frame_err;
    logic [7:0]  word_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int n_ferr   = 0;
    int exp_ferr = 0;

    logic [15:0] sb_data[$];
    logic        sb_pad[$];
    logic [7:0]  exp_wcnt = 8'd0;
    logic [15:0] last_data = 16'h0;

    sti_deserializer #(.CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .si_data   (si_data),
        .si_valid  (si_valid),
        .pi_length (pi_length),
        .pi_msb    (pi_msb),
        .pi_low    (pi_low),
        .pi_fill   (pi_fill),
        .po_data   (po_data),
        .po_valid  (po_valid),
        .pad_err   (pad_err),
        .frame_err (frame_err),
        .word_cnt  (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one frame; cut>0 drops si_valid after that many bits.
    task automatic send_frame(input logic [1:0] len, input logic msb, input logic low,
                              input logic fill, input logic [31:0] field,
                              input logic [15:0] exp_data, input logic exp_pad,
                              input int cut, input bit b2b);
        int n;
        int nb;
        n  = (int'(len) + 1) * 8;
        nb = (cut > 0) ? cut : n;
        if (cut == 0) begin
            sb_data.push_back(exp_data);
            sb_pad.push_back(exp_pad);
        end else begin
            exp_ferr++;
        end
        for (int i = 0; i < nb; i++) begin
            @(posedge clk); #1;
            si_valid = 1'b1;
            si_data  = msb ? field[n-1-i] : field[i];
            if (i == 0) begin
                pi_length = len;
                pi_msb    = msb;
                pi_low    = low;
                pi_fill   = fill;
            end else begin
                pi_length = 2'($urandom);
                pi_msb    = 1'($urandom);
                pi_low    = 1'($urandom);
                pi_fill   = 1'($urandom);
            end
        end
        if (!b2b) begin
            @(posedge clk); #1;
            si_valid = 1'b0;
            si_data  = 1'b0;
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && sb_data.size() != 0; k++) @(posedge clk);
        repeat (2) @(posedge clk);
        check("sb_drain", sb_data.size(), 0);
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        logic [15:0] ed;
        logic        ep;
        if (!reset) begin
            exp_wcnt = 8'd0;
        end else begin
            if (po_valid && frame_err) check("vld_ferr_overlap", 1, 0);
            if (frame_err) n_ferr++;
            if (po_valid) begin
                if (sb_data.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    ed = sb_data.pop_front();
                    ep = sb_pad.pop_front();
                    exp_wcnt  = exp_wcnt + 8'd1;
                    last_data = ed;
                    check("po_data", po_data, ed);
                    check("pad_err", pad_err, ep);
                    check("word_cnt", word_cnt, exp_wcnt);
                end
            end
        end
    end

    initial begin
        reset = 1'b0; si_data = 1'b0; si_valid = 1'b0;
        pi_length = 2'd0; pi_msb = 1'b0; pi_low = 1'b0; pi_fill = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("rst_po_data", po_data, 0);
        check("rst_po_valid", po_valid, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_word_cnt", word_cnt, 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);

        send_frame(2'd1, 1'b1, 1'b0, 1'b0, 32'h0000A5C3, 16'hA5C3, 1'b0, 0, 0);
        send_frame(2'd0, 1'b0, 1'b1, 1'b0, 32'h00000096, 16'h9600, 1'b0, 0, 0);
        send_frame(2'd0, 1'b0, 1'b0, 1'b0, 32'h00000096, 16'h0096, 1'b0, 0, 0);
        send_frame(2'd3, 1'b1, 1'b0, 1'b1, 32'h12340000, 16'h1234, 1'b0, 0, 0);
        send_frame(2'd3, 1'b1, 1'b0, 1'b1, 32'h12340001, 16'h1234, 1'b1, 0, 0);
        send_frame(2'd2, 1'b0, 1'b0, 1'b0, 32'h0000BEEF, 16'hBEEF, 1'b0, 0, 1);
        send_frame(2'd1, 1'b1, 1'b0, 1'b0, 32'h00000F0F, 16'h0F0F, 1'b0, 0, 0);
        drain();
        check("b2b_word_cnt", word_cnt, 7);

        // Early drop: no word, outputs hold.
        send_frame(2'd1, 1'b1, 1'b0, 1'b0, 32'h0000FFFF, 16'h0000, 1'b0, 5, 0);
        repeat (4) @(posedge clk); #1;
        check("ferr_hold_data", po_data, 16'h0F0F);
        check("ferr_hold_cnt", word_cnt, 7);
        check("ferr_count", n_ferr, 1);
        send_frame(2'd1, 1'b0, 1'b0, 1'b0, 32'h00001357, 16'h1357, 1'b0, 0, 0);
        send_frame(2'd2, 1'b1, 1'b0, 1'b1, 32'h00CAFE80, 16'hCAFE, 1'b1, 0, 0);
        send_frame(2'd3, 1'b0, 1'b0, 1'b0, 32'h00008001, 16'h8001, 1'b0, 0, 0);
        send_frame(2'd3, 1'b1, 1'b0, 1'b0, 32'h00018001, 16'h8001, 1'b1, 0, 0);
        send_frame(2'd2, 1'b0, 1'b1, 1'b1, 32'h00ABCD00, 16'hABCD, 1'b0, 0, 0);
        drain();

        // Reset in the middle of a 32-bit frame.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            si_valid = 1'b1; si_data = 1'($urandom);
            if (i == 0) begin pi_length = 2'd3; pi_msb = 1'b1; end
        end
        #2;
        reset = 1'b0;
        si_valid = 1'b0;
        #1;
        check("mid_rst_po_data", po_data, 0);
        check("mid_rst_po_valid", po_valid, 0);
        check("mid_rst_pad_err", pad_err, 0);
        check("mid_rst_frame_err", frame_err, 0);
        check("mid_rst_word_cnt", word_cnt, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        send_frame(2'd0, 1'b1, 1'b0, 1'b0, 32'h0000003C, 16'h003C, 1'b0, 0, 0);
        drain();
        check("post_rst_word_cnt", word_cnt, 1);
        check("post_rst_po_data", po_data, 16'h003C);
        check("total_frame_err", n_ferr, exp_ferr);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
